// File: rtl/metaball_sched_if.sv
// Ball-array broadcast/return and framebuffer write signals between the scheduler and its clients.
interface metaball_sched_if #(
    parameter int unsigned N_BALLS = 4
);
    logic                  mov_en;
    logic                  px_stb;
    logic [31:0]           p_x;
    logic [31:0]           p_y;
    logic [N_BALLS-1:0]    vld;
    logic [N_BALLS*32-1:0] out;
    logic                  wr_en;
    logic [10:0]           wr_addr;
    logic                  wr_data;
    logic                  wr_rdy;

    modport master (
        output mov_en, px_stb, p_x, p_y, wr_en, wr_addr, wr_data,
        input  vld, out, wr_rdy
    );

    modport slave (
        input  mov_en, px_stb, p_x, p_y, wr_en, wr_addr, wr_data,
        output vld, out, wr_rdy
    );
endinterface

// File: rtl/metaball_sched.sv
// Per-frame metaball scheduler: moves balls once, then strobes every pixel, sums the
// returned field contributions and writes one threshold bit per pixel to the framebuffer.
module metaball_sched #(
    parameter int unsigned N_BALLS   = 4,
    parameter int unsigned WIDTH_PX  = 32,
    parameter int unsigned HEIGHT_PX = 64,
    parameter logic [31:0] THRESH    = 32'h0000_8000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    metaball_sched_if.master bus,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun,
    output logic             timeout_err
);
    localparam int unsigned XW      = (WIDTH_PX  > 1) ? $clog2(WIDTH_PX)  : 1;
    localparam int unsigned YW      = (HEIGHT_PX > 1) ? $clog2(HEIGHT_PX) : 1;
    localparam int unsigned TW      = $clog2(TIMEOUT + 1);
    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE, ST_MOVE, ST_STROBE, ST_WAIT, ST_WRITE, ST_NEXT
    } state_t;

    state_t                    state, state_nxt;
    logic [XW-1:0]             px;
    logic [YW-1:0]             py;
    logic [N_BALLS-1:0]        mask, mask_c;
    logic [31:0]               sum, sum_c;
    logic [TW-1:0]             tmo, tmo_inc_c;
    logic [N_BALLS-1:0][31:0]  out_c;
    logic                      mask_full_c, tmo_hit_c, last_col_c, last_px_c;
    logic                      mov_en_nxt, px_stb_nxt, wr_en_nxt, busy_nxt, frame_done_nxt, wr_data_nxt;
    logic [10:0]               wr_addr_nxt;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, SAT_MAX}) ? SAT_MAX : s[31:0];
    endfunction

    assign out_c       = bus.out;
    assign mask_full_c = &mask_c;
    assign tmo_inc_c   = tmo + TW'(1);
    assign tmo_hit_c   = (tmo_inc_c == TW'(TIMEOUT));
    assign last_col_c  = (px == XW'(WIDTH_PX - 1));
    assign last_px_c   = last_col_c && (py == YW'(HEIGHT_PX - 1));
    assign bus.p_x     = 32'(px);
    assign bus.p_y     = 32'(py);

    // First vld per ball wins; negative (sign-magnitude) contributions add nothing.
    always_comb begin
        mask_c = mask;
        sum_c  = sum;
        if (state == ST_WAIT) begin
            for (int unsigned i = 0; i < N_BALLS; i++) begin
                if (bus.vld[i] && !mask[i]) begin
                    mask_c[i] = 1'b1;
                    if (!out_c[i][31]) sum_c = sat_add(sum_c, out_c[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (frame_tick) state_nxt = ST_MOVE;
            ST_MOVE:   state_nxt = ST_STROBE;
            ST_STROBE: state_nxt = ST_WAIT;
            ST_WAIT:   if (mask_full_c || tmo_hit_c) state_nxt = ST_WRITE;
            ST_WRITE:  if (bus.wr_rdy) state_nxt = ST_NEXT;
            ST_NEXT:   state_nxt = last_px_c ? ST_IDLE : ST_STROBE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the upcoming state.
    always_comb begin
        mov_en_nxt     = (state_nxt == ST_MOVE);
        px_stb_nxt     = (state_nxt == ST_STROBE);
        wr_en_nxt      = (state_nxt == ST_WRITE);
        busy_nxt       = (state_nxt != ST_IDLE);
        frame_done_nxt = (state_nxt == ST_NEXT) && last_px_c;
        wr_addr_nxt    = bus.wr_addr;
        wr_data_nxt    = bus.wr_data;
        if (state == ST_WAIT && state_nxt == ST_WRITE) begin
            wr_addr_nxt = 11'(32'(py) * WIDTH_PX + 32'(px));
            wr_data_nxt = (sum_c >= THRESH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mov_en  <= 1'b0;
            bus.px_stb  <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            px          <= '0;
            py          <= '0;
            mask        <= '0;
            sum         <= '0;
            tmo         <= '0;
        end else begin
            bus.mov_en  <= mov_en_nxt;
            bus.px_stb  <= px_stb_nxt;
            bus.wr_en   <= wr_en_nxt;
            bus.wr_addr <= wr_addr_nxt;
            bus.wr_data <= wr_data_nxt;
            busy        <= busy_nxt;
            frame_done  <= frame_done_nxt;
            if (frame_tick && state != ST_IDLE) overrun <= 1'b1;
            if (state == ST_WAIT && !mask_full_c && tmo_hit_c) timeout_err <= 1'b1;
            case (state)
                ST_STROBE: begin
                    mask <= '0;
                    sum  <= '0;
                    tmo  <= '0;
                end
                ST_WAIT: begin
                    mask <= mask_c;
                    sum  <= sum_c;
                    tmo  <= tmo_inc_c;
                end
                ST_NEXT: begin
                    if (last_px_c) begin
                        px <= '0;
                        py <= '0;
                    end else if (last_col_c) begin
                        px <= '0;
                        py <= py + YW'(1);
                    end else begin
                        px <= px + XW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/metaball_sched.md
METABALL_SCHED -- requirements
Module: metaball_sched

Interface
REQ-001 SHALL have parameter N_BALLS, default 4, number of metaball instances served.
REQ-002 SHALL have parameter WIDTH_PX, default 32, display columns.
REQ-003 SHALL have parameter HEIGHT_PX, default 64, display rows.
REQ-004 SHALL have parameter THRESH, default 32'h0000_8000, iso-surface threshold (1.0 in Q16.15).
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for vld per pixel.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port frame_tick  input  1  single-cycle 60 Hz frame request.
REQ-009 SHALL have port mov_en  output  1  move strobe broadcast to all balls.
REQ-010 SHALL have port px_stb  output  1  new-pixel strobe broadcast to all balls.
REQ-011 SHALL have ports p_x and p_y  output  32 each  pixel sample coordinates (integer).
REQ-012 SHALL have port vld  input  N_BALLS  per-ball calculation-complete flags.
REQ-013 SHALL have port out  input  N_BALLS*32  per-ball contributions, ball i at bits [32i+31:32i].
REQ-014 SHALL have ports wr_en  output  1, wr_addr  output  11, wr_data  output  1  framebuffer write request.
REQ-015 SHALL have port wr_rdy  input  1  framebuffer accepts write when high with wr_en.
REQ-016 SHALL have ports busy  output  1, frame_done  output  1 (pulse), overrun  output  1 (sticky), timeout_err  output  1 (sticky).

Function
REQ-017 SHALL implement states IDLE, MOVE, STROBE, WAIT, WRITE, NEXT.
REQ-018 IDLE: frame_tick high -> MOVE next cycle; busy low only in IDLE.
REQ-019 MOVE: mov_en high exactly one cycle, then STROBE with pixel (0,0).
REQ-020 STROBE: px_stb high exactly one cycle with current p_x/p_y; clears capture mask and timeout counter; -> WAIT.
REQ-021 WAIT: each cycle vld[i] high captures out[i] and sets mask bit i; later vld pulses on a set bit ignored.
REQ-022 WAIT: mask all-ones (including bits set that cycle) -> WRITE next cycle.
REQ-023 WAIT: counter reaching TIMEOUT with mask incomplete -> WRITE, missing contributions treated as 0, timeout_err set.
REQ-024 Contribution with bit 31 set (negative, signed-magnitude) SHALL count as 0.
REQ-025 Sum SHALL be unsigned, saturating at 32'h7FFF_FFFF; wr_data = (sum >= THRESH).
REQ-026 WRITE: wr_en held high, wr_addr = p_y*WIDTH_PX + p_x, wr_data stable, until cycle with wr_rdy high; then NEXT.
REQ-027 NEXT: p_x increments; at WIDTH_PX-1 wraps to 0 and p_y increments; -> STROBE.
REQ-028 NEXT on pixel (WIDTH_PX-1, HEIGHT_PX-1): frame_done pulses one cycle, p_x=p_y=0, -> IDLE.
REQ-029 frame_tick while busy SHALL be dropped and set overrun; no queued frame.
REQ-030 frame_tick coincident with frame_done cycle SHALL count as overrun (ball moves at most once per frame).
REQ-031 mov_en and px_stb SHALL never be high in the same cycle.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, mask 0, p_x=p_y=0, all outputs 0, sticky flags cleared.
REQ-033 Reset mid-frame SHALL abandon the frame without frame_done; first frame_tick after release starts at MOVE.

Verification
REQ-034 Single frame, balls return vld 3 cycles after px_stb, wr_rdy tied high -> one mov_en, 2048 px_stb, 2048 writes addr 0..2047 in order, one frame_done.
REQ-035 Pixel with outs 0x4000,0x3000,0x1000,0x0 -> sum 0x8000, wr_data 1; outs 0x4000,0x3FFF,0,0 -> wr_data 0.
REQ-036 Out 0x8000_8000 on one ball plus 0x7FFF_FFFF on another -> negative ignored, sum saturates, wr_data 1.
REQ-037 Ball 2 never asserts vld -> WRITE entered 255 cycles after WAIT entry, timeout_err high, scan continues.
REQ-038 wr_rdy low 5 cycles -> wr_en/addr/data stable 6 cycles, no px_stb; frame_tick during scan -> overrun 1, no second mov_en.
REQ-039 rst_n low at pixel 100 -> outputs 0 immediately, no frame_done; next frame_tick -> mov_en then pixel (0,0).
